// File: rtl/chipper_router_p.sv
// Bufferless 5-port deflection router: stage 1 ejects the oldest local flit and
// injects from the local port, stage 2 routes slots oldest-first onto N/E/S/W.
module chipper_router_p #(
  parameter  int DATA_W = 3,
  parameter  int X_W    = 2,
  parameter  int Y_W    = 2,
  parameter  int AGE_W  = 2,
  parameter  int MY_X   = 1,
  parameter  int MY_Y   = 1,
  localparam int FLIT_W = 1 + AGE_W + X_W + Y_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] nin,
  input  logic [FLIT_W-1:0] ein,
  input  logic [FLIT_W-1:0] sin,
  input  logic [FLIT_W-1:0] win,
  input  logic [FLIT_W-1:0] lin,
  output logic              lin_ready,
  output logic [FLIT_W-1:0] nout,
  output logic [FLIT_W-1:0] eout,
  output logic [FLIT_W-1:0] sout,
  output logic [FLIT_W-1:0] wout,
  output logic [FLIT_W-1:0] lout,
  output logic [15:0]       deflect_cnt
);

  localparam int Y_LSB = DATA_W;
  localparam int X_LSB = DATA_W + Y_W;
  localparam int A_LSB = X_LSB + X_W;
  localparam int V_BIT = FLIT_W - 1;

  localparam logic [X_W-1:0] MY_XL = MY_X[X_W-1:0];
  localparam logic [Y_W-1:0] MY_YL = MY_Y[Y_W-1:0];

  localparam logic [1:0] P_N = 2'd0;
  localparam logic [1:0] P_E = 2'd1;
  localparam logic [1:0] P_S = 2'd2;
  localparam logic [1:0] P_W = 2'd3;

  function automatic logic f_vld(input logic [FLIT_W-1:0] f);
    return f[V_BIT];
  endfunction

  function automatic logic [AGE_W-1:0] f_age(input logic [FLIT_W-1:0] f);
    return f[A_LSB +: AGE_W];
  endfunction

  function automatic logic [X_W-1:0] f_x(input logic [FLIT_W-1:0] f);
    return f[X_LSB +: X_W];
  endfunction

  function automatic logic [Y_W-1:0] f_y(input logic [FLIT_W-1:0] f);
    return f[Y_LSB +: Y_W];
  endfunction

  function automatic logic f_local(input logic [FLIT_W-1:0] f);
    return (f_x(f) == MY_XL) && (f_y(f) == MY_YL);
  endfunction

  function automatic logic [FLIT_W-1:0] f_set_age(input logic [FLIT_W-1:0] f,
                                                  input logic [AGE_W-1:0] a);
    logic [FLIT_W-1:0] r;
    r = f;
    r[A_LSB +: AGE_W] = a;
    return r;
  endfunction

  function automatic logic [AGE_W-1:0] f_age_sat_inc(input logic [AGE_W-1:0] a);
    return (a == {AGE_W{1'b1}}) ? a : a + 1'b1;
  endfunction

  function automatic logic [15:0] f_cnt_sat_add(input logic [15:0] c, input logic [2:0] n);
    logic [16:0] s;
    s = {1'b0, c} + {14'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [FLIT_W-1:0] w_in [4];
  assign w_in[0] = nin;
  assign w_in[1] = ein;
  assign w_in[2] = sin;
  assign w_in[3] = win;

  // ---- stage 1: eject oldest local flit, inject local flit into a free slot ----
  logic              w_ej_hit;
  logic [1:0]        w_ej_idx;
  logic [2:0]        w_nvld;
  logic [2:0]        w_occ;
  logic              w_inj;
  logic [FLIT_W-1:0] w_slot_p0 [4];
  logic [FLIT_W-1:0] w_lout_p0;

  always_comb begin
    w_ej_hit = 1'b0;
    w_ej_idx = 2'd0;
    w_nvld   = 3'd0;
    for (int i = 0; i < 4; i++) begin
      w_nvld = w_nvld + {2'b0, f_vld(w_in[i])};
      if (f_vld(w_in[i]) && f_local(w_in[i]) &&
          (!w_ej_hit || (f_age(w_in[i]) > f_age(w_in[w_ej_idx])))) begin
        w_ej_hit = 1'b1;
        w_ej_idx = i[1:0];
      end
    end
    w_occ = w_nvld - {2'b0, w_ej_hit};
  end

  assign lin_ready = ~rst & (w_occ != 3'd4);
  assign w_inj     = f_vld(lin) & lin_ready;

  always_comb begin
    logic v_placed;
    v_placed  = 1'b0;
    w_lout_p0 = w_ej_hit ? w_in[w_ej_idx] : '0;
    for (int i = 0; i < 4; i++) begin
      w_slot_p0[i] = w_in[i];
      if (w_ej_hit && (w_ej_idx == i[1:0]))
        w_slot_p0[i] = '0;
      if (w_inj && !v_placed && !f_vld(w_slot_p0[i])) begin
        w_slot_p0[i] = f_set_age(lin, '0);
        v_placed     = 1'b1;
      end
    end
  end

  // ---- stage 2: oldest-first port allocation with deflection ----
  logic [FLIT_W-1:0] r_slot_p1 [4];
  logic [FLIT_W-1:0] r_lout_p1;
  logic [1:0]        w_rank [4];
  logic [FLIT_W-1:0] w_out_p1 [4];
  logic [2:0]        w_ndef;

  // Rank = number of valid slots that win priority over this one (older, or same age and lower index).
  always_comb begin
    for (int s = 0; s < 4; s++) begin
      w_rank[s] = 2'd0;
      for (int t = 0; t < 4; t++) begin
        if ((t != s) && f_vld(r_slot_p1[t]) &&
            ((f_age(r_slot_p1[t]) > f_age(r_slot_p1[s])) ||
             ((f_age(r_slot_p1[t]) == f_age(r_slot_p1[s])) && (t < s))))
          w_rank[s] = w_rank[s] + 2'd1;
      end
    end
  end

  always_comb begin
    logic [3:0]        v_free;
    logic              v_xok;
    logic              v_yok;
    logic              v_got;
    logic [1:0]        v_xp;
    logic [1:0]        v_yp;
    logic [1:0]        v_sel;
    logic [FLIT_W-1:0] v_f;
    v_free = 4'hF;
    v_xok  = 1'b0;
    v_yok  = 1'b0;
    v_got  = 1'b0;
    v_xp   = P_E;
    v_yp   = P_N;
    v_sel  = P_N;
    v_f    = '0;
    w_ndef = 3'd0;
    for (int p = 0; p < 4; p++) w_out_p1[p] = '0;
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < 4; s++) begin
        if (f_vld(r_slot_p1[s]) && (w_rank[s] == r[1:0])) begin
          v_f   = r_slot_p1[s];
          v_xok = (f_x(v_f) != MY_XL);
          v_xp  = (f_x(v_f) > MY_XL) ? P_E : P_W;
          v_yok = (f_y(v_f) != MY_YL);
          v_yp  = (f_y(v_f) < MY_YL) ? P_N : P_S;
          v_got = 1'b0;
          v_sel = P_N;
          if (v_xok && v_free[v_xp]) begin
            v_got = 1'b1;
            v_sel = v_xp;
          end else if (v_yok && v_free[v_yp]) begin
            v_got = 1'b1;
            v_sel = v_yp;
          end
          // At most four valid slots, so a free port always remains here.
          if (!v_got) begin
            for (int p = 3; p >= 0; p--)
              if (v_free[p]) v_sel = p[1:0];
            v_f    = f_set_age(v_f, f_age_sat_inc(f_age(v_f)));
            w_ndef = w_ndef + 3'd1;
          end
          v_free[v_sel]   = 1'b0;
          w_out_p1[v_sel] = v_f;
        end
      end
    end
  end

  // ---- stage 2 outputs ----
  logic [FLIT_W-1:0] r_out_p2 [4];
  logic [15:0]       r_defl_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_slot_p1[i] <= '0;
        r_out_p2[i]  <= '0;
      end
      r_lout_p1  <= '0;
      r_defl_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_slot_p1[i] <= w_slot_p0[i];
        r_out_p2[i]  <= w_out_p1[i];
      end
      r_lout_p1  <= w_lout_p0;
      r_defl_cnt <= f_cnt_sat_add(r_defl_cnt, w_ndef);
    end
  end

  assign nout        = r_out_p2[0];
  assign eout        = r_out_p2[1];
  assign sout        = r_out_p2[2];
  assign wout        = r_out_p2[3];
  assign lout        = r_lout_p1;
  assign deflect_cnt = r_defl_cnt;

endmodule

// File: doc/chipper_router_p.md
Name: chipper_router_p

Overview:
- Parametrised successor to the fixed 10-bit CHIPPER deflection router.
- A bufferless 5-port mesh router: North/East/South/West network ports plus a Local inject/eject port.
- Flit width, coordinate width and age width are parameters, and router position is set per instance.
- Adds oldest-first arbitration with age stamping, an injection handshake, a 2-stage pipeline, and a deflection statistics counter.

Parameters:
- DATA_W, 3, payload bits per flit.
- X_W, 2, destination X coordinate bits.
- Y_W, 2, destination Y coordinate bits.
- AGE_W, 2, age field bits; the age saturates at 2^AGE_W-1.
- MY_X, 1, X coordinate of this router.
- MY_Y, 1, Y coordinate of this router.
- FLIT_W, 1+AGE_W+X_W+Y_W+DATA_W (10 with the defaults), derived total flit width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- nin  in  FLIT_W  North input flit.
- ein  in  FLIT_W  East input flit.
- sin  in  FLIT_W  South input flit.
- win  in  FLIT_W  West input flit.
- lin  in  FLIT_W  Local injection flit; its MSB is the valid bit.
- lin_ready  out  1  combinational; the injection is accepted this cycle when lin valid and lin_ready are both 1.
- nout  out  FLIT_W  North output flit, registered.
- eout  out  FLIT_W  East output flit, registered.
- sout  out  FLIT_W  South output flit, registered.
- wout  out  FLIT_W  West output flit, registered.
- lout  out  FLIT_W  Ejected flit, registered.
- deflect_cnt  out  16  saturating count of deflections.

Behaviour:
- Flit layout, MSB to LSB: valid, age[AGE_W], dst_x[X_W], dst_y[Y_W], payload[DATA_W]. A flit with valid=0 is an empty slot and all its other fields are ignored.
- Slot/port priority order for tie-breaks is fixed: N=0, E=1, S=2, W=3.
- Reset: rst=1 clears both pipeline registers, nout, eout, sout, wout, lout and deflect_cnt to 0 asynchronously. Reset mid-traffic drops every in-flight flit. lin_ready is forced to 0 while rst=1.
- Stage 1 (eject/inject), registered at a clk edge:
  - "Local" means dst_x==MY_X and dst_y==MY_Y.
  - Among the valid Local flits on the four inputs, the oldest is ejected to lout at the next edge; an age tie goes to the lowest port index. Latency from input to lout is 1 cycle. lout valid=0 when nothing is ejected.
  - Other Local flits stay in their slots and are deflected in stage 2.
  - lin_ready = 1 when (valid inputs − ejected) < 4.
  - An accepted lin flit is written into the lowest-index empty slot with its age field forced to 0.
- Stage 2 (route/permute), registered:
  - Slots are processed in descending age order; an age tie goes to the lower slot index.
  - Productive direction: dst_x>MY_X → E; dst_x<MY_X → W; dst_y<MY_Y → N; dst_y>MY_Y → S.
  - Preference order: the X direction first, then the Y direction. If both are productive and the X port is taken, the Y port is used.
  - When no productive port is free, or the flit is Local, the flit is deflected to the lowest-index free port and its age increments, saturating at 2^AGE_W-1.
  - Empty slots produce valid=0 outputs. At most 4 valid flits are in a slot set, so every flit always gets a port; no flit is dropped.
- Latency from a network input to a network output is 2 cycles. Full throughput: a new set of flits every cycle.
- deflect_cnt adds the number of flits deflected in stage 2 each cycle and saturates at 0xFFFF (no wrap).
- Simultaneous inject and eject in one cycle is legal. The freed slot may take the injected flit.

Test Plan (defaults; MY_X=1, MY_Y=1):
- Straight pass: nin={v1, age0, x2, y1, p5}, others empty → eout carries that flit unchanged at cycle+2; all other outputs valid=0; deflect_cnt=0.
- Eject contention: nin age2 and ein age1, both dst (1,1) → lout = the N flit at cycle+1. The E flit appears at cycle+2 on the lowest free port, which is nout, with age2; deflect_cnt=1.
- Injection: 4 non-local valid inputs, lin valid → lin_ready=0. With 3 valid inputs → lin_ready=1, and the injected flit occupies the empty slot with age=0.
- Age arbitration: nin age0 and sin age3, both dst (2,1) → sout's flit takes eout; nin's flit is deflected to nout with age1.
- Age saturation / counter: deflect a flit with age3 → output age stays 3. Preload traffic for 65540 deflections → deflect_cnt holds 0xFFFF.
- Reset mid-traffic: assert rst with a full pipeline → all outputs are 0 immediately, before the next edge. After release, the first new flit appears after 2 cycles.
